// File: rtl/tdm_frame_arb_if.sv
// tdm_frame_arb_if: requester strobes, output handshake and drop pulses of tdm_frame_arb.
interface tdm_frame_arb_if #(parameter int DW = 256);
  logic          reqValid0, reqValid1, outReady, outValid, outSrc, drop0Incr, drop1Incr;
  logic [DW-1:0] reqPdata0, reqPdata1, outPdata;
  modport master (
    output reqValid0, reqPdata0, reqValid1, reqPdata1, outReady,
    input  outValid, outPdata, outSrc, drop0Incr, drop1Incr
  );
  modport slave (
    input  reqValid0, reqPdata0, reqValid1, reqPdata1, outReady,
    output outValid, outPdata, outSrc, drop0Incr, drop1Incr
  );
endinterface

// File: rtl/tdm_frame_arb.sv
// tdm_frame_arb: two-requester frame arbiter with one-frame holding buffers,
// a registered valid/ready output stage and overwrite drop pulses.
module tdm_frame_arb #(parameter int DW = 256) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        busy,
  tdm_frame_arb_if.slave bus
);
  typedef enum logic [1:0] {DISABLED, RUN, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d, drop_q, drop_d, req_v, unmask, elig, granted;
  logic [DW-1:0] hold_q [2];
  logic [DW-1:0] hold_d [2];
  logic [DW-1:0] req_d [2];
  logic [DW-1:0] out_pdata_q, out_pdata_d;
  logic          out_valid_q, out_valid_d, out_src_q, out_src_d, last_q, last_d;
  logic          run, grant, win;
  assign req_v    = {bus.reqValid1, bus.reqValid0};
  assign req_d[0] = bus.reqPdata0;
  assign req_d[1] = bus.reqPdata1;
  assign run      = state_q == RUN;
  assign unmask   = {mode != 2'b00, mode != 2'b01};
  assign elig     = {2{run}} & unmask & (pend_q | req_v);
  assign grant    = run & (~out_valid_q | bus.outReady) & |elig;
  // Tie: round-robin picks the source not granted last, fixed priority picks src1.
  assign win      = &elig ? (mode[0] | ~last_q) : elig[1];
  assign granted  = {grant & win, grant & ~win};
  always_comb begin
    state_d     = state_q == DISABLED ? (enable ? RUN : DISABLED)
                : state_q == RUN      ? (enable ? RUN : DRAIN)
                : enable ? RUN : (~out_valid_q | bus.outReady) ? DISABLED : DRAIN;
    out_valid_d = grant | (out_valid_q & ~bus.outReady);
    out_pdata_d = grant ? (pend_q[win] ? hold_q[win] : req_d[win]) : out_pdata_q;
    out_src_d   = grant ? win : out_src_q;
    last_d      = grant ? win : last_q;
    for (int i = 0; i < 2; i++) begin
      pend_d[i] = (state_d == RUN) & run & unmask[i]
                & (granted[i] ? pend_q[i] & req_v[i] : pend_q[i] | req_v[i]);
      hold_d[i] = (run & unmask[i] & req_v[i] & (~granted[i] | pend_q[i])) ? req_d[i] : hold_q[i];
      drop_d[i] = run & unmask[i] & ~granted[i] & req_v[i] & pend_q[i];
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= DISABLED;
      pend_q      <= '0;
      drop_q      <= '0;
      hold_q      <= '{default: '0};
      out_pdata_q <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      hold_q      <= hold_d;
      out_pdata_q <= out_pdata_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
    end
  end
  assign busy          = state_q != DISABLED;
  assign bus.outValid  = out_valid_q;
  assign bus.outPdata  = out_pdata_q;
  assign bus.outSrc    = out_src_q;
  assign bus.drop0Incr = drop_q[0];
  assign bus.drop1Incr = drop_q[1];
endmodule

// File: tb/tb_tdm_frame_arb.sv
// tb_tdm_frame_arb: directed scenarios plus randomized traffic against a
// frame-level reference model of the arbiter.
module tb_tdm_frame_arb;
  localparam int DW = 256;
  logic clk = 0, rstn = 0, en = 0, busy;
  logic [1:0] mode = 2'd2;
  int total = 0, bad = 0;
  tdm_frame_arb_if #(.DW(DW)) b();
  tdm_frame_arb #(.DW(DW)) dut (.clk(clk), .rstn(rstn), .enable(en), .mode(mode), .busy(busy), .bus(b));
  always #5 clk = ~clk;
  logic [DW+4:0] obs;
  assign obs = {busy, b.outValid, b.outSrc, b.drop0Incr, b.drop1Incr, b.outPdata};
  // reference model state
  int            m_state;
  logic [1:0]    m_pend, m_drop;
  logic [DW-1:0] m_buf [2];
  logic [DW-1:0] m_od;
  logic          m_ov, m_os, m_last;
  localparam logic [DW-1:0] A = {32{8'hA5}};
  localparam logic [DW-1:0] B = {32{8'h3C}};
  localparam logic [DW-1:0] Z = '0;

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pend = 0; m_drop = 0; m_buf[0] = '0; m_buf[1] = '0;
    m_od = '0; m_ov = 0; m_os = 0; m_last = 1;
  endtask

  task automatic model(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic r);
    logic [DW-1:0] d [2];
    logic [1:0] um, ok;
    logic run, have, w;
    int ns;
    d[0] = d0; d[1] = d1;
    run = m_state == 1;
    case (mode)
      2'd0: um = 2'b01;
      2'd1: um = 2'b10;
      default: um = 2'b11;
    endcase
    for (int i = 0; i < 2; i++) ok[i] = run && um[i] && (m_pend[i] || v[i]);
    have = run && (!m_ov || r) && ok != 0;
    w = (ok == 2'b11) ? ((mode == 2'd3) ? 1'b1 : !m_last) : ok[1];
    if (m_state == 0) ns = en ? 1 : 0;
    else if (m_state == 1) ns = en ? 1 : 2;
    else ns = en ? 1 : ((m_ov && !r) ? 2 : 0);
    if (have) begin
      m_od = m_pend[w] ? m_buf[w] : d[w];
      m_os = w; m_last = w; m_ov = 1;
    end else if (r) m_ov = 0;
    for (int i = 0; i < 2; i++) begin
      m_drop[i] = 0;
      if (!(run && um[i])) m_pend[i] = 0;
      else if (have && int'(w) == i) begin
        if (m_pend[i] && v[i]) m_buf[i] = d[i];
        else m_pend[i] = 0;
      end else if (v[i]) begin
        m_drop[i] = m_pend[i]; m_buf[i] = d[i]; m_pend[i] = 1;
      end
    end
    if (ns != 1) m_pend = 0;
    m_state = ns;
  endtask

  task automatic cyc(input logic v0, input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1, input logic r);
    b.reqValid0 = v0; b.reqPdata0 = d0; b.reqValid1 = v1; b.reqPdata1 = d1; b.outReady = r;
    model({v1, v0}, d0, d1, r);
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] md);
    rstn = 0; en = 0; mode = md;
    b.reqValid0 = 0; b.reqValid1 = 0; b.reqPdata0 = '0; b.reqPdata1 = '0; b.outReady = 0;
    @(posedge clk);
    #1;
    rstn = 1;
    model_reset();
    en = 1;
    cyc(0, Z, 0, Z, 1);
  endtask

  task automatic test_reset();
    rstn = 0; en = 0;
    b.reqValid0 = 0; b.reqValid1 = 0; b.reqPdata0 = '0; b.reqPdata1 = '0; b.outReady = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (obs !== {5'b0, Z}) begin bad++; $display("FAIL reset_state got %h exp %h", obs, {5'b0, Z}); end
  endtask

  task automatic test_single();
    start(2'd2);
    total++; if (obs !== {5'b10000, Z}) begin bad++; $display("FAIL single_enable got %h exp %h", obs, {5'b10000, Z}); end
    cyc(1, A, 0, Z, 1);
    total++; if (obs !== {5'b11000, A}) begin bad++; $display("FAIL single_out got %h exp %h", obs, {5'b11000, A}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b10000, A}) begin bad++; $display("FAIL single_idle got %h exp %h", obs, {5'b10000, A}); end
  endtask

  task automatic test_round_robin();
    start(2'd2);
    cyc(1, A, 1, B, 1);
    total++; if (obs !== {5'b11000, A}) begin bad++; $display("FAIL rr_first got %h exp %h", obs, {5'b11000, A}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b11100, B}) begin bad++; $display("FAIL rr_second got %h exp %h", obs, {5'b11100, B}); end
  endtask

  task automatic test_fixed_priority();
    start(2'd3);
    cyc(1, A, 1, B, 1);
    total++; if (obs !== {5'b11100, B}) begin bad++; $display("FAIL fixed_first got %h exp %h", obs, {5'b11100, B}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b11000, A}) begin bad++; $display("FAIL fixed_second got %h exp %h", obs, {5'b11000, A}); end
  endtask

  task automatic test_overwrite();
    logic [DW-1:0] d1, d2, d3;
    d1 = rnd(); d2 = rnd(); d3 = rnd();
    start(2'd2);
    cyc(0, Z, 1, d1, 0);
    total++; if (obs !== {5'b11100, d1}) begin bad++; $display("FAIL ovw_d1 got %h exp %h", obs, {5'b11100, d1}); end
    cyc(0, Z, 1, d2, 0);
    total++; if (obs !== {5'b11100, d1}) begin bad++; $display("FAIL ovw_hold got %h exp %h", obs, {5'b11100, d1}); end
    cyc(0, Z, 1, d3, 0);
    total++; if (obs !== {5'b11101, d1}) begin bad++; $display("FAIL ovw_drop got %h exp %h", obs, {5'b11101, d1}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b11100, d3}) begin bad++; $display("FAIL ovw_d3 got %h exp %h", obs, {5'b11100, d3}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b10100, d3}) begin bad++; $display("FAIL ovw_empty got %h exp %h", obs, {5'b10100, d3}); end
  endtask

  task automatic test_mask();
    start(2'd0);
    cyc(0, Z, 1, B, 1);
    total++; if (obs !== {5'b10000, Z}) begin bad++; $display("FAIL mask_src1 got %h exp %h", obs, {5'b10000, Z}); end
    cyc(1, A, 0, Z, 0);
    cyc(1, B, 0, Z, 0);
    mode = 2'd1;
    cyc(0, Z, 0, Z, 0);
    total++; if (obs !== {5'b11000, A}) begin bad++; $display("FAIL mask_switch got %h exp %h", obs, {5'b11000, A}); end
    cyc(0, Z, 1, ~A, 1);
    total++; if (obs !== {5'b11100, ~A}) begin bad++; $display("FAIL mask_src1_pass got %h exp %h", obs, {5'b11100, ~A}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b10100, ~A}) begin bad++; $display("FAIL mask_discard got %h exp %h", obs, {5'b10100, ~A}); end
  endtask

  task automatic test_drain();
    start(2'd2);
    cyc(1, A, 0, Z, 0);
    en = 0;
    cyc(0, Z, 0, Z, 0);
    total++; if (obs !== {5'b11000, A}) begin bad++; $display("FAIL drain_enter got %h exp %h", obs, {5'b11000, A}); end
    cyc(1, B, 1, B, 0);
    total++; if (obs !== {5'b11000, A}) begin bad++; $display("FAIL drain_ignore got %h exp %h", obs, {5'b11000, A}); end
    cyc(0, Z, 0, Z, 1);
    total++; if (obs !== {5'b00000, A}) begin bad++; $display("FAIL drain_done got %h exp %h", obs, {5'b00000, A}); end
    cyc(1, B, 1, B, 1);
    total++; if (obs !== {5'b00000, A}) begin bad++; $display("FAIL disabled_ignore got %h exp %h", obs, {5'b00000, A}); end
  endtask

  task automatic test_reset_in_drain();
    start(2'd2);
    cyc(0, Z, 1, B, 0);
    en = 0;
    cyc(0, Z, 0, Z, 0);
    total++; if (obs !== {5'b11100, B}) begin bad++; $display("FAIL rst_drain_pre got %h exp %h", obs, {5'b11100, B}); end
    #2 rstn = 0;
    #1;
    total++; if (obs !== {5'b0, Z}) begin bad++; $display("FAIL rst_drain_async got %h exp %h", obs, {5'b0, Z}); end
    model_reset();
  endtask

  task automatic test_random();
    start(2'd2);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(39) == 0) en = !en;
      cyc(1'($urandom_range(1)), rnd(), 1'($urandom_range(1)), rnd(), $urandom_range(3) != 0);
      total++;
      if (obs !== {m_state != 0, m_ov, m_os, m_drop[0], m_drop[1], m_od}) begin
        bad++; $display("FAIL random_cycle%0d got %h exp %h", k, obs, {m_state != 0, m_ov, m_os, m_drop[0], m_drop[1], m_od});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_overwrite();
    test_mask();
    test_drain();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
